multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, giving cycles per memory access (legal 1..15).
REQ-002 The block SHALL have parameter OPCODE_W, default 6, giving the Opcode width (legal values: 6 only; the parameter exists for the instruction-format header).
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 Opcode  input  OPCODE_W  instruction opcode from the instruction register, stable from DECODE until return to FETCH.
REQ-006 IorD, IRWrite, PCWrite, MemWrite, Branch, BranchNe, ALUSrcA, RegWrite, MemtoReg, RegDst  output  1 each  datapath controls.
REQ-007 PCSrc, ALUSrcB, ALUOp  output  2 each  datapath mux selects and ALU operation class.
REQ-008 Illegal  output  1  unrecognised opcode flag; State  output  4  current state code, for debug.

Function
REQ-009 The block SHALL be a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BRNE=12. Codes 13-15 SHALL go to FETCH on the next edge.
REQ-010 All outputs SHALL be 0 except those listed per state below; all outputs except Illegal SHALL depend only on State and the memory counter.
REQ-011 FETCH: ALUSrcB=01. IRWrite=1 and PCWrite=1 only in the last access cycle.
REQ-012 DECODE: ALUSrcB=11.
REQ-013 MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
REQ-014 MEMRD: IorD=1.
REQ-015 MEMWB: RegWrite=1, MemtoReg=1.
REQ-016 MEMWR: IorD=1, MemWrite=1 in every cycle of the access.
REQ-017 EXEC: ALUSrcA=1, ALUOp=10.
REQ-018 ALUWB: RegWrite=1, RegDst=1.
REQ-019 ADDIWB: RegWrite=1.
REQ-020 BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
REQ-021 BRNE: same as BRANCH, but with BranchNe=1 instead of Branch=1.
REQ-022 JUMP: PCSrc=10, PCWrite=1.
REQ-023 Memory counter (4 bits): FETCH, MEMRD and MEMWR SHALL hold for MEM_LAT cycles.
  - The counter SHALL increment each cycle in these states.
  - The state SHALL advance when the counter equals MEM_LAT-1; the counter SHALL clear to 0 on that advance.
  - With MEM_LAT=1, each memory state SHALL last one cycle.
REQ-024 Transitions:
  - FETCH->DECODE.
  - DECODE on Opcode: 100011 or 101011 ->MEMADR; 000000->EXEC; 000100->BRANCH; 001000->ADDIEX; 000010->JUMP; 000101->BRNE (see REQ-031); else ->FETCH.
  - MEMADR: 100011->MEMRD, otherwise ->MEMWR.
  - MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, BRNE, JUMP ->FETCH.
REQ-025 Illegal SHALL be 1 combinationally while State=DECODE and the Opcode is unrecognised, and 0 otherwise.
REQ-026 Instruction cycle counts SHALL be (L=MEM_LAT):
  - lw = 3+2L
  - sw = 2+2L
  - R-type and addi = 3+L
  - beq, bne and j = 2+L
  - illegal = 1+L

Reset
REQ-027 On a rising edge with RST=1, State SHALL become FETCH and the counter SHALL become 0, regardless of current state, including mid-access.
REQ-028 After reset, outputs SHALL be: ALUSrcB=01, IRWrite=PCWrite=(MEM_LAT==1), all others 0.
REQ-029 A MEMWR access aborted by reset SHALL drop MemWrite in the cycle following the reset edge.
REQ-030 RST held high SHALL keep State=FETCH and counter=0.

Configuration
REQ-031 Macro BNE_INSTR_EN:
  - Defined: Opcode 000101 in DECODE SHALL go to BRNE.
  - Undefined: BRNE SHALL be unreachable, 000101 SHALL be illegal (Illegal=1, ->FETCH), and BranchNe SHALL be tied 0.
  - The port list SHALL be identical in both builds.

Verification
REQ-032 MEM_LAT=1, RST pulse, then Opcode=100011 -> States 0,1,2,3,4; RegWrite=1 and MemtoReg=1 in state 4; back at 0 on the 6th cycle.
REQ-033 MEM_LAT=3, Opcode=101011 -> FETCH lasts 3 cycles with IRWrite=1 only in the 3rd; MEMWR lasts 3 cycles with MemWrite=1 in all 3; total 8 cycles.
REQ-034 MEM_LAT=1, Opcode sequence 000000, 001000, 000100, 000010 -> RegDst=1 in ALUWB; ALUSrcB=10 in ADDIEX; Branch=1 with PCSrc=01; PCWrite=1 with PCSrc=10.
REQ-035 Opcode=111111 -> Illegal=1 for the one DECODE cycle, then FETCH; no RegWrite or MemWrite pulse.
REQ-036 MEM_LAT=4, RST asserted in the 2nd MEMWR cycle -> State=0, counter=0 and MemWrite=0 after that edge.
REQ-037 Opcode=000101: with BNE_INSTR_EN -> State=12 and BranchNe=1; without it -> Illegal=1 and BranchNe=0 throughout.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] Opcode;
  logic                IorD;
  logic                IRWrite;
  logic                PCWrite;
  logic                MemWrite;
  logic                Branch;
  logic                BranchNe;
  logic                ALUSrcA;
  logic                RegWrite;
  logic                MemtoReg;
  logic                RegDst;
  logic [1:0]          PCSrc;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic                Illegal;
  logic [3:0]          State;

  modport master (
    input  Opcode,
    output IorD, IRWrite, PCWrite, MemWrite, Branch, BranchNe, ALUSrcA,
           RegWrite, MemtoReg, RegDst, PCSrc, ALUSrcB, ALUOp, Illegal, State
  );

  modport slave (
    output Opcode,
    input  IorD, IRWrite, PCWrite, MemWrite, Branch, BranchNe, ALUSrcA,
           RegWrite, MemtoReg, RegDst, PCSrc, ALUSrcB, ALUOp, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a MIPS-style multicycle datapath with variable memory latency.
// Optional macro BNE_INSTR_EN adds the bne instruction (BRNE state, BranchNe output).
module multicycle_controller #(
  parameter int MEM_LAT  = 1,
  parameter int OPCODE_W = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_BRNE   = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       branch;
    logic       branchne;
    logic       alusrca;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
`ifdef BNE_INSTR_EN
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [3:0]          LAST_CNT = 4'(MEM_LAT - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  ctrl_t               r_ctrl;
  state_t              w_next_state;
  logic [3:0]          w_next_cnt;
  logic                w_mem_state;
  logic                w_mem_done;
  logic                w_legal;
  logic [OPCODE_W-1:0] w_opcode;

  // Datapath controls as a pure function of (state, counter); used on the next-state values
  // so the registered outputs line up with the state they belong to.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] cnt);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = (cnt == LAST_CNT);
        c.pcwrite = (cnt == LAST_CNT);
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_BRNE: begin
        c.alusrca  = 1'b1;
        c.aluop    = 2'b01;
        c.pcsrc    = 2'b01;
`ifdef BNE_INSTR_EN
        c.branchne = 1'b1;
`endif
      end
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign w_opcode    = bus.Opcode;
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_mem_done  = (r_cnt == LAST_CNT);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = S_FETCH;
    w_next_cnt   = 4'd0;
    w_legal      = 1'b1;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
`ifdef BNE_INSTR_EN
          OP_BNE:       w_next_state = S_BRNE;
`endif
          default: begin
            w_next_state = S_FETCH;
            w_legal      = 1'b0;
          end
        endcase
      end
      S_MEMADR: w_next_state = (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next_state = S_MEMWB;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      default:  w_next_state = S_FETCH;
    endcase
    // Memory states hold until the access has run for MEM_LAT cycles.
    if (w_mem_state && !w_mem_done) begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_cnt   <= 4'd0;
      r_ctrl  <= decode_ctrl(S_FETCH, 4'd0);
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_ctrl  <= decode_ctrl(w_next_state, w_next_cnt);
    end
  end

  assign bus.IorD     = r_ctrl.iord;
  assign bus.IRWrite  = r_ctrl.irwrite;
  assign bus.PCWrite  = r_ctrl.pcwrite;
  assign bus.MemWrite = r_ctrl.memwrite;
  assign bus.Branch   = r_ctrl.branch;
  assign bus.BranchNe = r_ctrl.branchne;
  assign bus.ALUSrcA  = r_ctrl.alusrca;
  assign bus.RegWrite = r_ctrl.regwrite;
  assign bus.MemtoReg = r_ctrl.memtoreg;
  assign bus.RegDst   = r_ctrl.regdst;
  assign bus.PCSrc    = r_ctrl.pcsrc;
  assign bus.ALUSrcB  = r_ctrl.alusrcb;
  assign bus.ALUOp    = r_ctrl.aluop;
  assign bus.State    = r_state;
  assign bus.Illegal  = (r_state == S_DECODE) && !w_legal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller at MEM_LAT = 1, 3 and 4; honours BNE_INSTR_EN.
module tb_multicycle_controller;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  multicycle_controller_if #(.OPCODE_W(6)) if_a ();
  multicycle_controller_if #(.OPCODE_W(6)) if_b ();
  multicycle_controller_if #(.OPCODE_W(6)) if_c ();

  multicycle_controller #(.MEM_LAT(1), .OPCODE_W(6)) dut_a (.CLK(clk), .RST(rst_a), .bus(if_a.master));
  multicycle_controller #(.MEM_LAT(3), .OPCODE_W(6)) dut_b (.CLK(clk), .RST(rst_b), .bus(if_b.master));
  multicycle_controller #(.MEM_LAT(4), .OPCODE_W(6)) dut_c (.CLK(clk), .RST(rst_c), .bus(if_c.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.Opcode = 6'b100011;
    if_b.Opcode = 6'b101011;
    if_c.Opcode = 6'b101011;

    // ---- MEM_LAT=1: lw walk 0,1,2,3,4,0
    tick();
    check("a_rst_state",   32'(if_a.State),    32'd0);
    check("a_rst_alusrcb", 32'(if_a.ALUSrcB),  32'd1);
    check("a_rst_irwrite", 32'(if_a.IRWrite),  32'd1);
    check("a_rst_pcwrite", 32'(if_a.PCWrite),  32'd1);
    check("a_rst_regwr",   32'(if_a.RegWrite), 32'd0);
    rst_a = 1'b0;
    tick(); check("lw_decode", 32'(if_a.State), 32'd1);
    check("lw_decode_alusrcb", 32'(if_a.ALUSrcB), 32'd3);
    check("lw_decode_irwrite", 32'(if_a.IRWrite), 32'd0);
    tick(); check("lw_memadr", 32'(if_a.State), 32'd2);
    check("lw_memadr_alusrca", 32'(if_a.ALUSrcA), 32'd1);
    check("lw_memadr_alusrcb", 32'(if_a.ALUSrcB), 32'd2);
    tick(); check("lw_memrd", 32'(if_a.State), 32'd3);
    check("lw_memrd_iord", 32'(if_a.IorD), 32'd1);
    tick(); check("lw_memwb", 32'(if_a.State), 32'd4);
    check("lw_memwb_regwrite", 32'(if_a.RegWrite), 32'd1);
    check("lw_memwb_memtoreg", 32'(if_a.MemtoReg), 32'd1);
    tick(); check("lw_back_fetch", 32'(if_a.State), 32'd0);
    check("lw_fetch_irwrite", 32'(if_a.IRWrite), 32'd1);

    // ---- R-type
    if_a.Opcode = 6'b000000;
    tick(); check("r_decode", 32'(if_a.State), 32'd1);
    tick(); check("r_exec", 32'(if_a.State), 32'd6);
    check("r_exec_aluop",   32'(if_a.ALUOp),   32'd2);
    check("r_exec_alusrca", 32'(if_a.ALUSrcA), 32'd1);
    tick(); check("r_aluwb", 32'(if_a.State), 32'd7);
    check("r_aluwb_regdst",   32'(if_a.RegDst),   32'd1);
    check("r_aluwb_regwrite", 32'(if_a.RegWrite), 32'd1);
    tick(); check("r_back_fetch", 32'(if_a.State), 32'd0);

    // ---- addi
    if_a.Opcode = 6'b001000;
    tick(); check("addi_decode", 32'(if_a.State), 32'd1);
    tick(); check("addi_exec", 32'(if_a.State), 32'd9);
    check("addi_exec_alusrcb", 32'(if_a.ALUSrcB), 32'd2);
    check("addi_exec_alusrca", 32'(if_a.ALUSrcA), 32'd1);
    tick(); check("addi_wb", 32'(if_a.State), 32'd10);
    check("addi_wb_regwrite", 32'(if_a.RegWrite), 32'd1);
    check("addi_wb_regdst",   32'(if_a.RegDst),   32'd0);
    tick(); check("addi_back_fetch", 32'(if_a.State), 32'd0);

    // ---- beq
    if_a.Opcode = 6'b000100;
    tick(); check("beq_decode", 32'(if_a.State), 32'd1);
    tick(); check("beq_branch", 32'(if_a.State), 32'd8);
    check("beq_branch_flag", 32'(if_a.Branch),   32'd1);
    check("beq_pcsrc",       32'(if_a.PCSrc),    32'd1);
    check("beq_aluop",       32'(if_a.ALUOp),    32'd1);
    check("beq_branchne",    32'(if_a.BranchNe), 32'd0);
    tick(); check("beq_back_fetch", 32'(if_a.State), 32'd0);

    // ---- j
    if_a.Opcode = 6'b000010;
    tick(); check("j_decode", 32'(if_a.State), 32'd1);
    tick(); check("j_jump", 32'(if_a.State), 32'd11);
    check("j_pcwrite", 32'(if_a.PCWrite), 32'd1);
    check("j_pcsrc",   32'(if_a.PCSrc),   32'd2);
    tick(); check("j_back_fetch", 32'(if_a.State), 32'd0);

    // ---- illegal opcode
    if_a.Opcode = 6'b111111;
    check("ill_fetch_flag", 32'(if_a.Illegal), 32'd0);
    tick(); check("ill_decode", 32'(if_a.State), 32'd1);
    check("ill_flag",     32'(if_a.Illegal),  32'd1);
    check("ill_regwrite", 32'(if_a.RegWrite), 32'd0);
    check("ill_memwrite", 32'(if_a.MemWrite), 32'd0);
    tick(); check("ill_back_fetch", 32'(if_a.State), 32'd0);
    check("ill_flag_clear", 32'(if_a.Illegal),  32'd0);
    check("ill_regwrite2",  32'(if_a.RegWrite), 32'd0);
    check("ill_memwrite2",  32'(if_a.MemWrite), 32'd0);

    // ---- bne, build-dependent
    if_a.Opcode = 6'b000101;
    tick(); check("bne_decode", 32'(if_a.State), 32'd1);
`ifdef BNE_INSTR_EN
    check("bne_legal", 32'(if_a.Illegal), 32'd0);
    tick(); check("bne_brne", 32'(if_a.State), 32'd12);
    check("bne_branchne", 32'(if_a.BranchNe), 32'd1);
    check("bne_branch",   32'(if_a.Branch),   32'd0);
    check("bne_pcsrc",    32'(if_a.PCSrc),    32'd1);
    tick(); check("bne_back_fetch", 32'(if_a.State), 32'd0);
`else
    check("bne_illegal",   32'(if_a.Illegal),  32'd1);
    check("bne_branchne0", 32'(if_a.BranchNe), 32'd0);
    tick(); check("bne_back_fetch", 32'(if_a.State), 32'd0);
    check("bne_branchne1", 32'(if_a.BranchNe), 32'd0);
`endif

    // ---- MEM_LAT=3: sw takes 3+1+1+3 = 8 cycles
    tick();
    check("b_rst_state",   32'(if_b.State),   32'd0);
    check("b_rst_alusrcb", 32'(if_b.ALUSrcB), 32'd1);
    check("b_fetch1_irwr", 32'(if_b.IRWrite), 32'd0);
    check("b_fetch1_pcwr", 32'(if_b.PCWrite), 32'd0);
    rst_b = 1'b0;
    tick(); check("b_fetch2_state", 32'(if_b.State), 32'd0);
    check("b_fetch2_irwr", 32'(if_b.IRWrite), 32'd0);
    tick(); check("b_fetch3_state", 32'(if_b.State), 32'd0);
    check("b_fetch3_irwr", 32'(if_b.IRWrite), 32'd1);
    check("b_fetch3_pcwr", 32'(if_b.PCWrite), 32'd1);
    tick(); check("b_decode", 32'(if_b.State), 32'd1);
    tick(); check("b_memadr", 32'(if_b.State), 32'd2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("b_memwr%0d_state", i), 32'(if_b.State),    32'd5);
      check($sformatf("b_memwr%0d_mw", i),    32'(if_b.MemWrite), 32'd1);
      check($sformatf("b_memwr%0d_iord", i),  32'(if_b.IorD),     32'd1);
    end
    tick(); check("b_cycle9_fetch", 32'(if_b.State), 32'd0);
    check("b_cycle9_mw", 32'(if_b.MemWrite), 32'd0);

    // ---- MEM_LAT=4: reset during the 2nd MEMWR cycle
    tick(); check("c_rst_state", 32'(if_c.State), 32'd0);
    rst_c = 1'b0;
    tick(); tick(); tick();
    check("c_fetch4_irwr", 32'(if_c.IRWrite), 32'd1);
    tick(); check("c_decode", 32'(if_c.State), 32'd1);
    tick(); check("c_memadr", 32'(if_c.State), 32'd2);
    tick(); check("c_memwr1", 32'(if_c.State), 32'd5);
    check("c_memwr1_mw", 32'(if_c.MemWrite), 32'd1);
    tick(); check("c_memwr2", 32'(if_c.State), 32'd5);
    check("c_memwr2_mw", 32'(if_c.MemWrite), 32'd1);
    rst_c = 1'b1;
    tick(); check("c_abort_state", 32'(if_c.State), 32'd0);
    check("c_abort_mw",    32'(if_c.MemWrite), 32'd0);
    check("c_abort_iord",  32'(if_c.IorD),     32'd0);
    check("c_abort_irwr",  32'(if_c.IRWrite),  32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("c_hold%0d_state", i), 32'(if_c.State),   32'd0);
      check($sformatf("c_hold%0d_irwr", i),  32'(if_c.IRWrite), 32'd0);
    end
    rst_c = 1'b0;
    tick(); check("c_refetch2_irwr", 32'(if_c.IRWrite), 32'd0);
    tick(); check("c_refetch3_irwr", 32'(if_c.IRWrite), 32'd0);
    check("c_refetch3_state", 32'(if_c.State), 32'd0);
    tick(); check("c_refetch4_irwr", 32'(if_c.IRWrite), 32'd1);
    check("c_refetch4_pcwr", 32'(if_c.PCWrite), 32'd1);
    tick(); check("c_refetch_decode", 32'(if_c.State), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
